// File: rtl/sb_config_loader.sv
// sb_config_loader: serial loader for a 3x3 switch-block select bus.
// Nine 12-bit beats are collected into a shadow register. The live select
// bus is then forced all-open for BREAK_CYCLES cycles (break-before-make)
// before the shadow is committed in one cycle.
module sb_config_loader #(
    parameter int unsigned BREAK_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [11:0]  cfg_data,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    output logic [107:0] select,
    output logic         busy,
    output logic         done,
    output logic         aborted
);

    localparam logic [3:0] LAST_BEAT  = 4'd8;
    localparam logic [3:0] BREAK_LAST = 4'(BREAK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BREAK = 2'd2,
        ST_MAKE  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [3:0]     cnt_r;        // beat index in LOAD, break cycle index in BREAK
    logic [3:0]     cnt_s;
    logic           beat_we_s;
    logic           abort_s;
    logic [6:0]     beat_lo_s;
    logic [107:0]   shadow_r;
    logic [107:0]   select_r;
    logic           busy_r;
    logic           done_r;
    logic           aborted_r;

    // Next-state logic; abort outranks a same-cycle transfer in LOAD.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        beat_we_s = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                    cnt_s   = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    abort_s = 1'b1;
                end else if (cfg_valid) begin
                    beat_we_s = 1'b1;
                    if (cnt_r == LAST_BEAT) begin
                        state_s = ST_BREAK;
                        cnt_s   = 4'd0;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_BREAK: begin
                if (cnt_r == BREAK_LAST) begin
                    state_s = ST_MAKE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_MAKE: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Low bit of the shadow field addressed by the current beat (row-major).
    always_comb begin
        beat_lo_s = {3'd0, cnt_r} * 7'd12;
    end

    // State and shared beat/break counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Shadow capture of accepted beats; cleared by reset so a partial load is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r <= 108'd0;
        end else if (beat_we_s) begin
            shadow_r[beat_lo_s +: 12] <= cfg_data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Registered outputs, each reflecting the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select_r  <= 108'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_MAKE);
            aborted_r <= abort_s;
            if (state_s == ST_BREAK) begin
                select_r <= 108'd0;
            end else if (state_s == ST_MAKE) begin
                select_r <= shadow_r;
            end else begin
                select_r <= select_r;
            end
        end
    end

    assign cfg_ready = (state_r == ST_LOAD);
    assign select    = select_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed bench for sb_config_loader: three builds (BREAK_CYCLES 2, 1, 15)
// share one stimulus stream so every break-window length is observed.
module tb_sb_config_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [11:0]  cfg_data;
    logic         cfg_valid;
    logic         rdy_a, rdy_b, rdy_c;
    logic [107:0] sel_a, sel_b, sel_c;
    logic         busy_a, busy_b, busy_c;
    logic         done_a, done_b, done_c;
    logic         abrt_a, abrt_b, abrt_c;

    int checks = 0;
    int errors = 0;

    logic [107:0] img1, ones, img_a5, img_g;

    always #5 clk = ~clk;

    sb_config_loader #(.BREAK_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy_a),
        .select(sel_a), .busy(busy_a), .done(done_a), .aborted(abrt_a)
    );

    sb_config_loader #(.BREAK_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy_b),
        .select(sel_b), .busy(busy_b), .done(done_b), .aborted(abrt_b)
    );

    sb_config_loader #(.BREAK_CYCLES(15)) dut_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy_c),
        .select(sel_c), .busy(busy_c), .done(done_c), .aborted(abrt_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [107:0] got, input logic [107:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outputs of one build, t cycles after the last beat transfer.
    task automatic chk_tail(input string tag, input int b, input int t, input logic [107:0] img,
                            input logic [107:0] sel, input logic dn, input logic bsy, input logic ab);
        check({tag, "_sel"}, sel, (t < b) ? 108'd0 : img);
        check({tag, "_done"}, 108'(dn), (t == b) ? 108'd1 : 108'd0);
        check({tag, "_busy"}, 108'(bsy), (t <= b) ? 108'd1 : 108'd0);
        check({tag, "_aborted"}, 108'(ab), 108'd0);
    endtask

    // All three builds idle with the given select value.
    task automatic chk_idle(input string tag, input logic [107:0] exp_sel);
        check({tag, "_sel_a"}, sel_a, exp_sel);
        check({tag, "_sel_b"}, sel_b, exp_sel);
        check({tag, "_sel_c"}, sel_c, exp_sel);
        check({tag, "_busy"}, 108'({busy_a, busy_b, busy_c}), 108'd0);
        check({tag, "_done"}, 108'({done_a, done_b, done_c}), 108'd0);
        check({tag, "_rdy"}, 108'({rdy_a, rdy_b, rdy_c}), 108'd0);
    endtask

    // Start, stream nine beats of img (gappy: valid 1,0,0,1,...), optionally follow the commit.
    task automatic do_load(input logic [107:0] img, input logic [107:0] prev,
                           input bit gappy, input bit tail, input bit poke);
        int  k;
        int  cyc;
        bit  vld;
        start = 1'b1;
        step();
        start = 1'b0;
        k   = 0;
        cyc = 1;
        while (k < 9 && cyc < 60) begin
            check("ld_rdy", 108'({rdy_a, rdy_b, rdy_c}), 108'd7);
            check("ld_sel_a", sel_a, prev);
            check("ld_sel_c", sel_c, prev);
            check("ld_busy", 108'({busy_a, busy_b, busy_c}), 108'd7);
            check("ld_done", 108'({done_a, done_b, done_c}), 108'd0);
            vld = !gappy || ((cyc - 1) % 3 == 0);
            cfg_valid = vld;
            cfg_data  = vld ? img[k*12 +: 12] : 12'hBAD;
            step();
            if (vld) k++;
            cyc++;
        end
        cfg_valid = 1'b0;
        cfg_data  = 12'h000;
        check("ld_beats", 108'(k), 108'd9);
        if (tail) begin
            for (int t = 0; t < 18; t++) begin
                chk_tail("a", 2, t, img, sel_a, done_a, busy_a, abrt_a);
                chk_tail("b", 1, t, img, sel_b, done_b, busy_b, abrt_b);
                chk_tail("c", 15, t, img, sel_c, done_c, busy_c, abrt_c);
                if (t == 0) check("brk_rdy", 108'(rdy_a), 108'd0);
                start = poke && (t == 0);
                abort = poke && (t == 0 || t == 1);
                step();
            end
            start = 1'b0;
            abort = 1'b0;
            chk_idle("post", img);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 9; k++) begin
            img1[k*12 +: 12]   = 12'(k + 1);
            img_a5[k*12 +: 12] = 12'h0A5;
            img_g[k*12 +: 12]  = 12'(12'h300 + 12'(k * 17));
        end
        ones = {108{1'b1}};

        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 12'h000;
        step();
        step();
        chk_idle("rst", 108'd0);
        check("rst_aborted", 108'({abrt_a, abrt_b, abrt_c}), 108'd0);
        rst = 1'b0;
        step();
        chk_idle("rel", 108'd0);

        // Basic load 001..009, start/abort poked during the break window.
        do_load(img1, 108'd0, 1'b0, 1'b1, 1'b1);
        check("row1col1", 108'(sel_a[11:0]), 108'h001);
        check("row3col3", 108'(sel_a[107:96]), 108'h009);

        // All-ones then 0A5 in every field.
        do_load(ones, img1, 1'b0, 1'b1, 1'b0);
        do_load(img_a5, ones, 1'b0, 1'b1, 1'b0);

        // Abort together with the fifth beat.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = 12'(12'h111 * (k + 1));
            step();
        end
        cfg_valid = 1'b1;
        cfg_data  = 12'h555;
        abort     = 1'b1;
        step();
        cfg_valid = 1'b0;
        abort     = 1'b0;
        check("abort_pulse", 108'({abrt_a, abrt_b, abrt_c}), 108'd7);
        chk_idle("abort", img_a5);
        step();
        check("abort_once", 108'({abrt_a, abrt_b, abrt_c}), 108'd0);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        check("idle_abort", 108'({abrt_a, abrt_b, abrt_c}), 108'd0);
        chk_idle("idle_abort", img_a5);

        // Full load with stalls after the abort.
        do_load(img_g, img_a5, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset during BREAK.
        do_load(img1, img_g, 1'b0, 1'b0, 1'b0);
        check("brk_open", sel_a, 108'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst", 108'd0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_idle("after_rst", 108'd0);
        end

        // Full load after the reset commits normally.
        do_load(img_a5, 108'd0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_config_loader.md
SB_CONFIG_LOADER -- requirements
Module: sb_config_loader

Interface
REQ-001 Parameter: BREAK_CYCLES, default 2, number of all-open cycles inserted before a new configuration is applied (legal 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  single-cycle request to begin a reconfiguration.
REQ-005 Port: abort  input  1  cancels a load in progress.
REQ-006 Port: cfg_data  input  12  select word for one bidir switch.
REQ-007 Port: cfg_valid  input  1  cfg_data is valid.
REQ-008 Port: cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-009 Port: select  output  108  registered switch-block select bus, 9 switches x 12 bits.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle pulse when a new configuration is applied.
REQ-012 Port: aborted  output  1  one-cycle pulse when a load is cancelled.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, BREAK and MAKE.
REQ-014 IDLE: start=1 -> LOAD with beat counter cleared to 0; abort SHALL be ignored in IDLE.
REQ-015 cfg_ready SHALL be 1 only in LOAD; a beat transfers when cfg_valid && cfg_ready.
REQ-016 Beat k (0..8) SHALL be written to shadow[12k+11:12k], so beat 0 drives switch position row1/col1 and beat 8 drives row3/col3 (row-major).
REQ-017 The beat counter SHALL increment on each transfer; the transfer with counter=8 SHALL move LOAD -> BREAK.
REQ-018 cfg_valid=0 in LOAD SHALL stall with no timeout; shadow and counter are held.
REQ-019 abort=1 in LOAD SHALL take priority over a same-cycle transfer: the beat is discarded, the state goes to IDLE, aborted pulses next cycle, and select is unchanged.
REQ-020 select SHALL NOT change during IDLE or LOAD.
REQ-021 BREAK: select SHALL be 108'b0 (all switches open) for exactly BREAK_CYCLES cycles, then -> MAKE.
REQ-022 MAKE: select SHALL be loaded with shadow, and done SHALL pulse for that one cycle; the next state is IDLE.
REQ-023 abort and start SHALL be ignored in BREAK and MAKE, making the commit atomic once the break begins.
REQ-024 start SHALL be ignored in LOAD, BREAK and MAKE.
REQ-025 Latency from start to done with cfg_valid held high SHALL be 1 + 9 + BREAK_CYCLES cycles.
REQ-026 Outputs SHALL be registered, with no combinational path from inputs to select, done, aborted or busy; cfg_ready SHALL depend only on state.
REQ-027 A new start SHALL be accepted in the cycle after MAKE.

Reset
REQ-028 rst=1 SHALL force, asynchronously: state=IDLE, select=0, shadow=0, counter=0, done=0, aborted=0, busy=0.
REQ-029 rst asserted mid-LOAD or mid-BREAK SHALL discard the partial configuration; after release, select SHALL stay 0 until a full load completes.

Verification
REQ-030 Reset then start, nine beats 12'h001..12'h009 with no gaps -> cfg_ready high for 9 cycles, select=0 for 2 cycles, then select[11:0]=12'h001 and select[107:96]=12'h009, done=1 for 1 cycle, done at cycle 12 after start.
REQ-031 Load all-ones (12'hFFF x9), then a second load of 12'h0A5 x9 -> select stays 108'hFFF..F through the second LOAD, is 0 for BREAK_CYCLES cycles, then becomes 12'h0A5 in every field.
REQ-032 Start, 4 beats, abort asserted together with the 5th beat -> aborted pulses, busy drops, select keeps the prior value, the 5th beat is not stored, and a following full load succeeds.
REQ-033 Start, beats with cfg_valid toggled 1,0,0,1,... -> exactly 9 transfers are counted, field order is preserved, and done arrives only after the 9th transfer.
REQ-034 BREAK_CYCLES=1 and BREAK_CYCLES=15 builds -> all-open window of 1 and 15 cycles respectively; abort and start pulsed during BREAK have no effect.
REQ-035 rst pulsed (asynchronously, between clock edges) during BREAK -> select=0 immediately and busy=0, no done pulse, and state is IDLE after release.
